mult_seq_n: RTL and testbench

Parametrised sequential signed/unsigned add-shift multiplier with a start/done handshake. It generalises the board-level 8-bit switch multiplier to W bits and adds the following:
- a selectable unsigned mode;
- operand latching at start;
- Run edge detection, so a held button runs one multiply only;
- Busy and Done status outputs.

It sits between the switch/button debouncers and the hex-display drivers, which show Aval:Bval.

---
 rtl/mult_seq_n.sv | 117 +++++++++++
 tb/tb_mult_seq_n.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_n.sv
// Sequential add-shift multiplier, W-bit signed or unsigned operands, 2W-bit product in {Aval,Bval}.
// One ADD and one SHIFT state per multiplier bit; Run acts on its rising edge only.
module mult_seq_n #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Run,
  input  logic         ClearA_LoadB,
  input  logic         Signed_Mode,
  input  logic [W-1:0] Din,
  output logic [W-1:0] Aval,
  output logic [W-1:0] Bval,
  output logic         X,
  output logic         Busy,
  output logic         Done
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  s_q, s_d;
  logic          x_q, x_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          run_q, run_d;

  logic               start;
  logic signed [W:0]  a_ext;
  logic signed [W:0]  s_ext;
  logic signed [W:0]  sum;

  assign start = Run & ~run_q;
  assign a_ext = mode_q ? {a_q[W-1], a_q} : {1'b0, a_q};
  assign s_ext = mode_q ? {s_q[W-1], s_q} : {1'b0, s_q};
  // The last multiplier bit carries negative weight in two's complement.
  assign sum   = (mode_q && (cnt_q == LAST)) ? (a_ext - s_ext) : (a_ext + s_ext);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    run_d   = Run;
    case (state_q)
      IDLE, DONE: begin
        if (ClearA_LoadB) begin
          a_d     = '0;
          x_d     = 1'b0;
          b_d     = Din;
          state_d = IDLE;
        end else if (start) begin
          a_d     = '0;
          x_d     = 1'b0;
          s_d     = Din;
          mode_d  = Signed_Mode;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        if (b_q[0]) {x_d, a_d} = sum;
        state_d = SHIFT;
      end
      SHIFT: begin
        x_d = mode_q & x_q;
        a_d = {x_q, a_q[W-1:1]};
        b_d = {a_q[0], b_q[W-1:1]};
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ADD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Run_q resets high so a Run held through reset is not seen as an edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      run_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      run_q   <= run_d;
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;
  assign Busy = (state_q == ADD) || (state_q == SHIFT);
  assign Done = (state_q == DONE);

endmodule

// File: tb/tb_mult_seq_n.sv
// Bench for mult_seq_n: W=8 and W=16 instances, expected products queued at start, checked at Done.
module tb_mult_seq_n;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Run = 1'b0;
  logic        ClearA_LoadB = 1'b0;
  logic        Signed_Mode = 1'b1;
  logic [7:0]  Din = '0;
  logic [7:0]  Aval, Bval;
  logic        X, Busy, Done;

  logic        Run16 = 1'b0;
  logic        CL16 = 1'b0;
  logic        SM16 = 1'b1;
  logic [15:0] Din16 = '0;
  logic [15:0] Aval16, Bval16;
  logic        X16, Busy16, Done16;

  int checks = 0;
  int errors = 0;
  logic [7:0] b_model = '0;

  typedef struct packed {
    logic [31:0] prod;
    logic        x;
  } exp_t;
  exp_t sb[$];

  always #5 Clk = ~Clk;

  mult_seq_n #(.W(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
    .Signed_Mode(Signed_Mode), .Din(Din), .Aval(Aval), .Bval(Bval),
    .X(X), .Busy(Busy), .Done(Done)
  );

  mult_seq_n #(.W(16)) dut16 (
    .Clk(Clk), .Reset(Reset), .Run(Run16), .ClearA_LoadB(CL16),
    .Signed_Mode(SM16), .Din(Din16), .Aval(Aval16), .Bval(Bval16),
    .X(X16), .Busy(Busy16), .Done(Done16)
  );

  function automatic exp_t model(input logic [15:0] s, input logic [15:0] b,
                                 input logic sm, input int w);
    exp_t   e;
    longint sv, bv, p, mask;
    sv = longint'(s) & ((64'sd1 <<< w) - 1);
    bv = longint'(b) & ((64'sd1 <<< w) - 1);
    if (sm && ((sv >>> (w - 1)) & 1) == 1) sv = sv - (64'sd1 <<< w);
    if (sm && ((bv >>> (w - 1)) & 1) == 1) bv = bv - (64'sd1 <<< w);
    p      = sv * bv;
    mask   = (64'sd1 <<< (2 * w)) - 1;
    e.prod = 32'(p & mask);
    e.x    = sm && (p < 0);
    return e;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] b);
    ClearA_LoadB = 1'b1;
    Din = b;
    tick();
    ClearA_LoadB = 1'b0;
    b_model = b;
    checks++;
    if (Bval !== b || Aval !== 8'h00 || Done !== 1'b0) begin
      errors++;
      $display("FAIL load: Bval=%h Aval=%h Done=%b, required Bval=%h Aval=00 Done=0", Bval, Aval, Done, b);
    end
  endtask

  task automatic start8(input logic [7:0] din, input logic sm);
    Din = din;
    Signed_Mode = sm;
    sb.push_back(model(16'(din), 16'(b_model), sm, 8));
    Run = 1'b1;
    tick();
    Run = 1'b0;
  endtask

  // perturb: 0 none, 1 toggle Signed_Mode/Din, 2 pulse Run and ClearA_LoadB
  task automatic finish8(input int perturb, input string name);
    int   n = 0;
    int   busy_n = 0;
    exp_t e;
    while (!Done && n < 200) begin
      if (Busy) busy_n++;
      if (perturb == 1) begin
        Signed_Mode = ~Signed_Mode;
        Din = 8'($urandom);
      end else if (perturb == 2) begin
        Run = n[0];
        ClearA_LoadB = 1'b1;
        Din = 8'($urandom);
      end
      tick();
      n++;
    end
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    checks++;
    if (!Done) begin
      errors++;
      $display("FAIL %s timeout: Done=%b after %0d cycles, required 1", name, Done, n);
    end
    checks++;
    if (busy_n != 16) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, required 16", name, busy_n);
    end
    e = sb.pop_front();
    checks++;
    if (Aval !== e.prod[15:8] || Bval !== e.prod[7:0] || X !== e.x) begin
      errors++;
      $display("FAIL %s product: got A=%h B=%h X=%b, required A=%h B=%h X=%b",
               name, Aval, Bval, X, e.prod[15:8], e.prod[7:0], e.x);
    end
    b_model = e.prod[7:0];
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    checks++;
    if (Aval !== 8'h00 || Bval !== 8'h00 || X !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: A=%h B=%h X=%b Busy=%b Done=%b, required all 0", Aval, Bval, X, Busy, Done);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_signed();
    load8(8'h03); start8(8'h02, 1'b1); finish8(0, "s_3x2");
    start8(8'h05, 1'b1); finish8(0, "s_chain_6x5");
    load8(8'hFE); start8(8'h03, 1'b1); finish8(0, "s_m2x3");
    load8(8'hF5); start8(8'hFD, 1'b1); finish8(0, "s_m11xm3");
    load8(8'h80); start8(8'h80, 1'b1); finish8(0, "s_m128sq");
    load8(8'h7F); start8(8'h80, 1'b1); finish8(0, "s_127xm128");
  endtask

  task automatic test_unsigned();
    load8(8'hFF); start8(8'hFF, 1'b0); finish8(0, "u_ffxff");
    load8(8'hFF); start8(8'hFF, 1'b0); finish8(1, "u_toggle_mode");
    load8(8'h80); start8(8'h03, 1'b0); finish8(0, "u_80x03");
  endtask

  task automatic test_run_held();
    int   busy_n = 0;
    int   rises = 0;
    logic prev_done;
    exp_t e;
    load8(8'h05);
    Din = 8'h07;
    Signed_Mode = 1'b1;
    sb.push_back(model(16'h0007, 16'(b_model), 1'b1, 8));
    prev_done = Done;
    Run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Busy) busy_n++;
      if (Done && !prev_done) rises++;
      prev_done = Done;
    end
    Run = 1'b0;
    checks++;
    if (busy_n != 16 || rises != 1) begin
      errors++;
      $display("FAIL run_held: busy_cycles=%0d done_rises=%0d, required 16 and 1", busy_n, rises);
    end
    e = sb.pop_front();
    checks++;
    if ({Aval, Bval} !== e.prod[15:0]) begin
      errors++;
      $display("FAIL run_held product: got %h%h, required %h", Aval, Bval, e.prod[15:0]);
    end
    b_model = e.prod[7:0];
  endtask

  task automatic test_ignore_busy();
    load8(8'h03); start8(8'h09, 1'b1); finish8(2, "busy_ignore");
    tick();
    tick();
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0 || Bval !== 8'h1B) begin
      errors++;
      $display("FAIL done_hold: Done=%b Busy=%b Bval=%h, required 1 0 1b", Done, Busy, Bval);
    end
  endtask

  task automatic test_reset_mid();
    load8(8'h25);
    start8(8'h13, 1'b1);
    repeat (7) tick();
    Reset = 1'b1;
    #1;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Aval !== 8'h00 || Bval !== 8'h00 || X !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: Busy=%b Done=%b A=%h B=%h X=%b, required all 0", Busy, Done, Aval, Bval, X);
    end
    void'(sb.pop_front());
    b_model = 8'h00;
    tick();
    Reset = 1'b0;
    tick();
    load8(8'h0C); start8(8'h0B, 1'b1); finish8(0, "after_reset");
  endtask

  task automatic test_run_through_reset();
    int busy_n = 0;
    Reset = 1'b1;
    Run = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (Busy || Done) busy_n++;
    end
    Run = 1'b0;
    checks++;
    if (busy_n != 0) begin
      errors++;
      $display("FAIL run_through_reset: active cycles=%0d, required 0", busy_n);
    end
    b_model = 8'h00;
    tick();
  endtask

  task automatic test_w16();
    int   n = 0;
    int   busy_n = 0;
    exp_t e;
    CL16 = 1'b1;
    Din16 = 16'd300;
    tick();
    CL16 = 1'b0;
    Din16 = 16'hFFF9;
    SM16 = 1'b1;
    sb.push_back(model(16'hFFF9, 16'd300, 1'b1, 16));
    Run16 = 1'b1;
    tick();
    Run16 = 1'b0;
    while (!Done16 && n < 200) begin
      if (Busy16) busy_n++;
      tick();
      n++;
    end
    e = sb.pop_front();
    checks++;
    if (busy_n != 32 || Done16 !== 1'b1) begin
      errors++;
      $display("FAIL w16 timing: busy_cycles=%0d Done=%b, required 32 and 1", busy_n, Done16);
    end
    checks++;
    if (Aval16 !== e.prod[31:16] || Bval16 !== e.prod[15:0] || X16 !== e.x) begin
      errors++;
      $display("FAIL w16 product: got A=%h B=%h X=%b, required A=%h B=%h X=%b",
               Aval16, Bval16, X16, e.prod[31:16], e.prod[15:0], e.x);
    end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_run_held();
    test_ignore_busy();
    test_reset_mid();
    test_run_through_reset();
    test_w16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
